// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory controller: MMIO register map and STATUS layout.
// Also provides the MMIO address decoder used by dmem_ctrl.
package dmem_ctrl_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
    localparam logic [31:0] TXDATA_OFF  = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF  = 32'h0000_0004;
    localparam logic [31:0] CYCLE_OFF   = 32'h0000_0008;

    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE | TXDATA_OFF;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE | STATUS_OFF;
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE | CYCLE_OFF;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_COUNT_LSB = 2;
    localparam int STATUS_COUNT_W   = 5;

    typedef enum logic [1:0] {
        MMIO_NONE,
        MMIO_TXDATA,
        MMIO_STATUS,
        MMIO_CYCLE
    } mmio_reg_e;

    // Byte offset within the register word is ignored; unmapped words decode to NONE.
    function automatic mmio_reg_e mmio_decode(input logic [31:0] addr);
        mmio_reg_e sel;
        sel = MMIO_NONE;
        if (addr[31:2] == TXDATA_ADDR[31:2]) sel = MMIO_TXDATA;
        else if (addr[31:2] == STATUS_ADDR[31:2]) sel = MMIO_STATUS;
        else if (addr[31:2] == CYCLE_ADDR[31:2]) sel = MMIO_CYCLE;
        return sel;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core-side data memory bus. An access is accepted in any cycle where mem_oe && mem_ready;
// mem_valid pulses the cycle after an accepted read (mem_we == 0) with mem_rdata.
interface dmem_ctrl_if;
    logic [31:0] mem_addr;
    logic        mem_oe;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_oe, mem_wdata, mem_we,
        input  mem_rdata, mem_valid, mem_ready
    );

    modport slave (
        input  mem_addr, mem_oe, mem_wdata, mem_we,
        output mem_rdata, mem_valid, mem_ready
    );
endinterface

// File: rtl/dmem_ctrl_tx_fifo.sv
// Synchronous FIFO for the UART byte stream; full pushes and empty pops are ignored.
// Head entry reads as zero while empty so the downstream sees clean data after reset.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-enabled RAM plus optional MMIO (UART TX FIFO, STATUS, CYCLE).
// The MMIO block is built only when DMEM_MMIO_EN is defined; otherwise every access hits RAM.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    logic [31:0]       ram [2**ADDR_W];
    logic [1:0]        off;
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              is_write;
    logic              is_mmio;
    logic [6:0]        lanes_wide;
    logic [3:0]        lanes;
    logic [31:0]       wdata_sh;
    logic              ram_we;
    logic [31:0]       mmio_rd;
    logic [31:0]       read_word;
    logic              valid_q;
    logic [31:0]       rdata_q;

    assign off      = bus.mem_addr[1:0];
    assign idx      = bus.mem_addr[ADDR_W+1:2];
    assign accept   = bus.mem_oe && bus.mem_ready;
    assign is_write = |bus.mem_we;

    // Lanes pushed beyond byte 3 are simply lost: no split across words.
    assign lanes_wide = {3'b000, bus.mem_we} << off;
    assign lanes      = lanes_wide[3:0];
    assign wdata_sh   = bus.mem_wdata << {off, 3'b000};

    assign ram_we = accept && is_write && !is_mmio && !rst;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && lanes[i]) ram[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
    end

    // A write in the previous cycle has already landed in the array, so reads are write-first.
    assign read_word = is_mmio ? mmio_rd : ram[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            valid_q <= accept && !is_write;
            if (accept && !is_write) rdata_q <= read_word >> {off, 3'b000};
        end
    end

    // Masking with rst kills a read that was accepted just before reset asserted.
    assign bus.mem_valid = valid_q && !rst;
    assign bus.mem_rdata = rst ? '0 : rdata_q;

`ifdef DMEM_MMIO_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mmio_reg_e                 reg_sel;
    logic                      tx_sel_write;
    logic                      enq;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [STATUS_COUNT_W-1:0] cnt5;
    logic [31:0]               status_word;
    logic [31:0]               cycle_q;

    assign is_mmio      = bus.mem_addr[31];
    assign reg_sel      = mmio_decode(bus.mem_addr);
    assign tx_sel_write = is_mmio && (reg_sel == MMIO_TXDATA) && is_write;
    assign bus.mem_ready = !(bus.mem_oe && tx_sel_write && fifo_full);
    assign enq          = accept && tx_sel_write && !rst;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (enq),
        .push_data (bus.mem_wdata[7:0]),
        .pop       (tx_ready),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = !fifo_empty;

    assign cnt5        = STATUS_COUNT_W'(fifo_count);
    assign status_word = (32'(cnt5) << STATUS_COUNT_LSB)
                       | (32'(fifo_empty) << STATUS_EMPTY_BIT)
                       | (32'(fifo_full) << STATUS_FULL_BIT);

    always_comb begin
        mmio_rd = '0;
        case (reg_sel)
            MMIO_STATUS: mmio_rd = status_word;
            MMIO_CYCLE:  mmio_rd = cycle_q;
            default:     mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_q + 32'd1;
    end
`else
    logic unused_bits;

    assign is_mmio       = 1'b0;
    assign mmio_rd       = '0;
    assign bus.mem_ready = 1'b1;
    assign tx_valid      = 1'b0;
    assign tx_data       = '0;
    assign unused_bits   = ^{bus.mem_addr[31:ADDR_W+2], tx_ready};
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: RAM byte lanes, write-first, reset behaviour and,
// when DMEM_MMIO_EN is defined, the TX FIFO, STATUS and CYCLE registers.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic tx_ready;
    logic [7:0] tx_data;
    logic tx_valid;
    int vectors;
    int miscompares;

    dmem_ctrl_if bif ();

    dmem_ctrl #(.ADDR_W(14), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_bus(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
        bif.mem_addr  = addr;
        bif.mem_we    = we;
        bif.mem_wdata = wdata;
        bif.mem_oe    = 1'b1;
    endtask

    // One accepted access; returns sampled #1 after the edge.
    task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
        set_bus(addr, we, wdata);
        @(posedge clk); #1;
        bif.mem_oe = 1'b0;
        bif.mem_we = 4'b0000;
    endtask

    task automatic idle();
        bif.mem_oe = 1'b0;
        bif.mem_we = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bif.mem_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bif.mem_valid); end
        vectors++; if (bif.mem_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 00000000", bif.mem_rdata); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        vectors++; if (bif.mem_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bif.mem_ready); end
    endtask

    task automatic test_store_load();
        access(32'h0000_0100, 4'b1111, 32'h1234_5678);
        vectors++; if (bif.mem_valid !== 1'b0) begin miscompares++; $display("FAIL store_no_valid got %b want 0", bif.mem_valid); end
        access(32'h0000_0103, 4'b0000, 32'h0);
        vectors++; if (bif.mem_valid !== 1'b1) begin miscompares++; $display("FAIL lbu_valid got %b want 1", bif.mem_valid); end
        vectors++; if (bif.mem_rdata !== 32'h0000_0012) begin miscompares++; $display("FAIL lbu_rdata got %h want 00000012", bif.mem_rdata); end
        idle();
        vectors++; if (bif.mem_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got %b want 0", bif.mem_valid); end
        vectors++; if (bif.mem_rdata !== 32'h0000_0012) begin miscompares++; $display("FAIL rdata_hold got %h want 00000012", bif.mem_rdata); end
        access(32'h0000_0100, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL lw_rdata got %h want 12345678", bif.mem_rdata); end
        idle();
    endtask

    task automatic test_halfword();
        access(32'h0000_0100, 4'b1111, 32'h1122_3344);
        access(32'h0000_0102, 4'b0011, 32'h0000_BEEF);
        access(32'h0000_0100, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'hBEEF_3344) begin miscompares++; $display("FAIL sh_rdata got %h want beef3344", bif.mem_rdata); end
        // Halfword at offset 3: upper lane falls off the word
        access(32'h0000_0103, 4'b0011, 32'h0000_AABB);
        access(32'h0000_0100, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'hBBEF_3344) begin miscompares++; $display("FAIL sh_drop_rdata got %h want bbef3344", bif.mem_rdata); end
        access(32'h0000_0102, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'h0000_BBEF) begin miscompares++; $display("FAIL lhu_rdata got %h want 0000bbef", bif.mem_rdata); end
        idle();
    endtask

    task automatic test_back_to_back();
        access(32'h0000_0200, 4'b1111, 32'hCAFE_F00D);
        access(32'h0000_0200, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL raw_rdata got %h want cafef00d", bif.mem_rdata); end
        vectors++; if (bif.mem_valid !== 1'b1) begin miscompares++; $display("FAIL raw_valid got %b want 1", bif.mem_valid); end
        access(32'h0001_0200, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL alias_rdata got %h want cafef00d", bif.mem_rdata); end
        idle();
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_tx_fifo();
        logic [7:0] exp_q[$];
        tx_ready = 1'b0;
        access(STATUS_ADDR, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'h0000_0002) begin miscompares++; $display("FAIL status_empty got %h want 00000002", bif.mem_rdata); end
        for (int i = 0; i < 4; i++) begin
            access(TXDATA_ADDR, 4'b0001, 32'h0000_0041 + i);
            exp_q.push_back(8'h41 + 8'(i));
            if (i == 1) begin
                access(STATUS_ADDR, 4'b0000, 32'h0);
                vectors++; if (bif.mem_rdata !== 32'h0000_0008) begin miscompares++; $display("FAIL status_two got %h want 00000008", bif.mem_rdata); end
            end
        end
        access(STATUS_ADDR, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'h0000_0011) begin miscompares++; $display("FAIL status_full got %h want 00000011", bif.mem_rdata); end
        set_bus(TXDATA_ADDR, 4'b0001, 32'h0000_0045);
        #1;
        vectors++; if (bif.mem_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready got %b want 0", bif.mem_ready); end
        @(posedge clk); #1;
        vectors++; if (bif.mem_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready2 got %b want 0", bif.mem_ready); end
        vectors++; if (tx_data !== 8'h41) begin miscompares++; $display("FAIL head_41 got %h want 41", tx_data); end
        tx_ready = 1'b1;
        #1;
        vectors++; if (bif.mem_ready !== 1'b0) begin miscompares++; $display("FAIL no_bypass_ready got %b want 0", bif.mem_ready); end
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        tx_ready = 1'b0;
        #1;
        vectors++; if (bif.mem_ready !== 1'b1) begin miscompares++; $display("FAIL resume_ready got %b want 1", bif.mem_ready); end
        @(posedge clk); #1;
        exp_q.push_back(8'h45);
        bif.mem_oe = 1'b0;
        bif.mem_we = 4'b0000;
        tx_ready = 1'b1;
        while (exp_q.size() > 0) begin
            vectors++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin miscompares++; $display("FAIL tx_order got %b/%h want 1/%h", tx_valid, tx_data, exp_q[0]); end
            void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL drained_valid got %b want 0", tx_valid); end
    endtask

    task automatic test_mmio_misc();
        logic [31:0] c0;
        access(CYCLE_ADDR, 4'b0000, 32'h0);
        c0 = bif.mem_rdata;
        access(CYCLE_ADDR, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata - c0 !== 32'd1) begin miscompares++; $display("FAIL cycle_step got %h want 1", bif.mem_rdata - c0); end
        access(TXDATA_ADDR, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'h0 || bif.mem_valid !== 1'b1) begin miscompares++; $display("FAIL txdata_read got %h want 00000000", bif.mem_rdata); end
        access(32'h8000_000C, 4'b1111, 32'hFFFF_FFFF);
        access(32'h8000_000C, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got %h want 00000000", bif.mem_rdata); end
        access(STATUS_ADDR, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'h0000_0002) begin miscompares++; $display("FAIL unmapped_write got %h want 00000002", bif.mem_rdata); end
        idle();
    endtask
`else
    task automatic test_no_mmio();
        tx_ready = 1'b0;
        access(32'h8000_0000, 4'b1111, 32'hA5A5_5A5A);
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL nommio_tx_valid got %b want 0", tx_valid); end
        access(32'h0000_0000, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'hA5A5_5A5A) begin miscompares++; $display("FAIL nommio_rdata got %h want a5a55a5a", bif.mem_rdata); end
        set_bus(32'h8000_0000, 4'b1111, 32'h1);
        #1;
        vectors++; if (bif.mem_ready !== 1'b1) begin miscompares++; $display("FAIL nommio_ready got %b want 1", bif.mem_ready); end
        idle();
    endtask
`endif

    task automatic test_reset_read();
        access(32'h0000_0300, 4'b1111, 32'h0101_0101);
`ifdef DMEM_MMIO_EN
        access(TXDATA_ADDR, 4'b0001, 32'h0000_0055);
`endif
        access(32'h0000_0100, 4'b0000, 32'h0);
        rst = 1'b1;
        set_bus(32'h0000_0300, 4'b1111, 32'hFFFF_FFFF);
        #1;
        vectors++; if (bif.mem_valid !== 1'b0) begin miscompares++; $display("FAIL rst_kill_valid got %b want 0", bif.mem_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        bif.mem_oe = 1'b0;
        bif.mem_we = 4'b0000;
        #1;
        vectors++; if (bif.mem_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_valid got %b want 0", bif.mem_valid); end
        vectors++; if (bif.mem_rdata !== 32'h0) begin miscompares++; $display("FAIL post_rst_rdata got %h want 00000000", bif.mem_rdata); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_fifo got %b want 0", tx_valid); end
        @(posedge clk); #1;
        access(32'h0000_0300, 4'b0000, 32'h0);
        vectors++; if (bif.mem_rdata !== 32'h0101_0101) begin miscompares++; $display("FAIL rst_write_ignored got %h want 01010101", bif.mem_rdata); end
        idle();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        tx_ready = 1'b0;
        bif.mem_addr = '0;
        bif.mem_oe = 1'b0;
        bif.mem_wdata = '0;
        bif.mem_we = 4'b0000;
        #1;
        test_reset();
        test_store_load();
        test_halfword();
        test_back_to_back();
`ifdef DMEM_MMIO_EN
        test_tx_fifo();
        test_mmio_misc();
`else
        test_no_mmio();
`endif
        test_reset_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
